// File: rtl/boot_ram_arbiter.sv
// boot_ram_arbiter
//   Shares the four 8x2K boot SP RAM byte lanes (one 32-bit word per address)
//   between the CPU instruction-fetch port (i_*) and a data/loader port (d_*).
//   All lanes see one shared address/control set. Arbitration is combinational,
//   so a grant drives the RAM in the same cycle. The RAM answers one cycle
//   later, and the response is routed back to the port that owned the grant.
//
//   Optional feature macro: BOOT_RAM_LOCK_EN
//     When defined, a lock_set pulse sets a sticky write lock. Locked data
//     writes are still granted and acknowledged, but they touch no lane and
//     they return d_err=1. When undefined, lock_set is ignored and d_err is 0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req/i_addr               fetch request and byte address
//   i_gnt                      fetch request accepted this cycle
//   i_rvalid/i_rdata           fetch response, one cycle after i_gnt
//   d_req/d_we/d_be/d_addr/d_wdata  data request (read or byte-enabled write)
//   d_gnt                      data request accepted this cycle
//   d_rvalid/d_rdata/d_err     data response, one cycle after d_gnt
//   lock_set                   write-lock set pulse (lock build only)
//   ram_ce/ram_oce/ram_reset/ram_wre/ram_ad/ram_din  shared lane controls
//   ram_dout                   concatenated lane read data
module boot_ram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int STARVE_MAX = 4,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  input  logic                lock_set,
  output logic [DATA_W/8-1:0] ram_ce,
  output logic                ram_oce,
  output logic                ram_reset,
  output logic                ram_wre,
  output logic [ADDR_W-3:0]   ram_ad,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} resp_state_t;

  resp_state_t      resp_state_p1, resp_state_nxt;
  logic             we_p1, we_nxt;
  logic             err_p1, err_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             wr_block;
  logic             unused_bits;

  // The word address drops the byte offset; lock_set is only consumed in the
  // lock build.
  assign unused_bits = ^{i_addr[1:0], d_addr[1:0], lock_set};

  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

`ifdef BOOT_RAM_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lock_q <= 1'b0;
    else if (lock_set) lock_q <= 1'b1;
  end

  // A lock_set arriving with a write grant already blocks that write.
  assign wr_block = lock_q | lock_set;
`else
  assign wr_block = 1'b0;
`endif

  // ---- Stage p0: arbitration and RAM drive (combinational) ----
  // Grants are held off while reset is asserted so every output reads 0.
  always_comb begin
    d_gnt = rst_n && d_req && (!i_req || (starve_cnt == CNT_W'(STARVE_MAX)));
    i_gnt = rst_n && i_req && !d_gnt;
  end

  always_comb begin
    ram_ce         = '0;
    ram_wre        = 1'b0;
    ram_ad         = '0;
    ram_din        = '0;
    resp_state_nxt = IDLE;
    we_nxt         = 1'b0;
    err_nxt        = 1'b0;
    if (d_gnt) begin
      ram_ad         = d_addr[ADDR_W-1:2];
      resp_state_nxt = RESP_D;
      we_nxt         = d_we;
      if (d_we) begin
        ram_din = d_wdata;
        err_nxt = wr_block;
        if (!wr_block) begin
          ram_ce  = d_be;
          ram_wre = 1'b1;
        end
      end else begin
        ram_ce = '1;
      end
    end else if (i_gnt) begin
      ram_ad         = i_addr[ADDR_W-1:2];
      ram_ce         = '1;
      resp_state_nxt = RESP_I;
    end
  end

  // Data loses only to fetch; any other cycle (granted or idle) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (d_req && !d_gnt) begin
      if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // ---- Stage p1: response routing, aligned with RAM read data ----
  // Reset clears the owner, which drops any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_state_p1 <= IDLE;
      we_p1         <= 1'b0;
      err_p1        <= 1'b0;
    end else begin
      resp_state_p1 <= resp_state_nxt;
      we_p1         <= we_nxt;
      err_p1        <= err_nxt;
    end
  end

  always_comb begin
    i_rvalid = (resp_state_p1 == RESP_I);
    d_rvalid = (resp_state_p1 == RESP_D);
    i_rdata  = i_rvalid ? ram_dout : '0;
    d_rdata  = (d_rvalid && !we_p1) ? ram_dout : '0;
    d_err    = d_rvalid && err_p1;
  end

endmodule
